// File: rtl/alu_wrapper.sv
// Self-running 8-bit signed ALU: 16-entry ROM, fetch and execute stages.
// Optional macro WRAPPER_SATURATE_EN clamps ADD/SUB overflow results.
module alu_wrapper (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] data_out,
    output logic [2:0] data_type
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SAR = 3'd7;

    localparam logic [2:0] T_IDLE  = 3'd0;
    localparam logic [2:0] T_ARITH = 3'd1;
    localparam logic [2:0] T_LOGIC = 3'd2;
    localparam logic [2:0] T_SHIFT = 3'd3;
    localparam logic [2:0] T_OVF   = 3'd4;
    localparam logic [2:0] T_ZERO  = 3'd5;

    logic [3:0]  pc;
    logic [18:0] rom_word;

    logic        f_valid;
    logic [2:0]  f_op;
    logic [7:0]  f_a;
    logic [7:0]  f_b;

    logic [8:0]  sum9;
    logic        ovf;
    logic [7:0]  alu_res;
    logic [2:0]  alu_cls;
    logic [7:0]  res_next;
    logic [2:0]  type_next;

    // Instruction ROM: {op, a, b} selected by pc.
    always_comb begin
        case (pc)
            4'd0:    rom_word = {OP_ADD, 8'd100, 8'd27};
            4'd1:    rom_word = {OP_ADD, 8'd100, 8'd28};
            4'd2:    rom_word = {OP_SUB, 8'h9C,  8'd50};
            4'd3:    rom_word = {OP_SUB, 8'd5,   8'd5};
            4'd4:    rom_word = {OP_AND, 8'h3C,  8'h0F};
            4'd5:    rom_word = {OP_OR,  8'h30,  8'h05};
            4'd6:    rom_word = {OP_XOR, 8'h55,  8'h55};
            4'd7:    rom_word = {OP_SHL, 8'h41,  8'd1};
            4'd8:    rom_word = {OP_SAR, 8'hC0,  8'd2};
            4'd9:    rom_word = {OP_NOT, 8'h0F,  8'h00};
            4'd10:   rom_word = {OP_ADD, 8'hFF,  8'd1};
            4'd11:   rom_word = {OP_SUB, 8'h00,  8'h80};
            4'd12:   rom_word = {OP_SHL, 8'd1,   8'd7};
            4'd13:   rom_word = {OP_SAR, 8'hFF,  8'd7};
            4'd14:   rom_word = {OP_ADD, 8'hCE,  8'hCE};
            default: rom_word = {OP_SUB, 8'd10,  8'd20};
        endcase
    end

    // Fetch stage: latch the ROM entry and advance pc (wraps 15->0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= 4'd0;
            f_valid <= 1'b0;
            f_op    <= 3'd0;
            f_a     <= 8'd0;
            f_b     <= 8'd0;
        end else begin
            pc      <= pc + 4'd1;
            f_valid <= 1'b1;
            f_op    <= rom_word[18:16];
            f_a     <= rom_word[15:8];
            f_b     <= rom_word[7:0];
        end
    end

    // ALU core: 9-bit signed add/sub with overflow, logic and shifts.
    always_comb begin
        sum9    = 9'd0;
        ovf     = 1'b0;
        alu_res = 8'd0;
        alu_cls = T_IDLE;
        case (f_op)
            OP_ADD: begin
                sum9    = {f_a[7], f_a} + {f_b[7], f_b};
                alu_res = sum9[7:0];
                ovf     = sum9[8] ^ sum9[7];
                alu_cls = T_ARITH;
            end
            OP_SUB: begin
                sum9    = {f_a[7], f_a} - {f_b[7], f_b};
                alu_res = sum9[7:0];
                ovf     = sum9[8] ^ sum9[7];
                alu_cls = T_ARITH;
            end
            OP_AND: begin
                alu_res = f_a & f_b;
                alu_cls = T_LOGIC;
            end
            OP_OR: begin
                alu_res = f_a | f_b;
                alu_cls = T_LOGIC;
            end
            OP_XOR: begin
                alu_res = f_a ^ f_b;
                alu_cls = T_LOGIC;
            end
            OP_NOT: begin
                alu_res = ~f_a;
                alu_cls = T_LOGIC;
            end
            OP_SHL: begin
                alu_res = f_a << f_b[2:0];
                alu_cls = T_SHIFT;
            end
            default: begin
                alu_res = $signed(f_a) >>> f_b[2:0];
                alu_cls = T_SHIFT;
            end
        endcase
    end

    // Result select and class priority: overflow, then zero, then op class.
    always_comb begin
        res_next = alu_res;
`ifdef WRAPPER_SATURATE_EN
        if (ovf) begin
            res_next = sum9[8] ? 8'h80 : 8'h7F;
        end
`endif
        if (ovf) begin
            type_next = T_OVF;
        end else if (res_next == 8'd0) begin
            type_next = T_ZERO;
        end else begin
            type_next = alu_cls;
        end
    end

    // Execute stage: register the result only for valid fetched entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out  <= 8'd0;
            data_type <= T_IDLE;
        end else if (f_valid) begin
            data_out  <= res_next;
            data_type <= type_next;
        end
    end

endmodule

// File: tb/tb_alu_wrapper.sv
// Directed checks for alu_wrapper: reset, full ROM pass, wrap, mid-run reset.
// Expected values follow the WRAPPER_SATURATE_EN build when it is defined.
module tb_alu_wrapper;

    logic       clk;
    logic       rst;
    logic [7:0] data_out;
    logic [2:0] data_type;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [7:0] d;
        logic [2:0] t;
    } vec_t;

    vec_t tbl [16];

    alu_wrapper dut (
        .clk       (clk),
        .rst       (rst),
        .data_out  (data_out),
        .data_type (data_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [7:0] exp_d,
                         input logic [2:0] exp_t);
        n_checks++;
        if (data_out !== exp_d || data_type !== exp_t) begin
            n_fail++;
            $display("FAIL %s: got %0d/%0d, expected %0d/%0d",
                     name, $signed(data_out), data_type,
                     $signed(exp_d), exp_t);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        tbl[0]  = '{8'd127, 3'd1};
`ifdef WRAPPER_SATURATE_EN
        tbl[1]  = '{8'h7F,  3'd4};
        tbl[2]  = '{8'h80,  3'd4};
`else
        tbl[1]  = '{8'h80,  3'd4};
        tbl[2]  = '{8'd106, 3'd4};
`endif
        tbl[3]  = '{8'd0,   3'd5};
        tbl[4]  = '{8'd12,  3'd2};
        tbl[5]  = '{8'd53,  3'd2};
        tbl[6]  = '{8'd0,   3'd5};
        tbl[7]  = '{8'h82,  3'd3};
        tbl[8]  = '{8'hF0,  3'd3};
        tbl[9]  = '{8'hF0,  3'd2};
        tbl[10] = '{8'd0,   3'd5};
`ifdef WRAPPER_SATURATE_EN
        tbl[11] = '{8'h7F,  3'd4};
`else
        tbl[11] = '{8'h80,  3'd4};
`endif
        tbl[12] = '{8'h80,  3'd3};
        tbl[13] = '{8'hFF,  3'd3};
        tbl[14] = '{8'h9C,  3'd1};
        tbl[15] = '{8'hF6,  3'd1};

        rst = 1'b0;
        #1;
        check("reset_t0", 8'd0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_hold%0d", i), 8'd0, 3'd0);
        end

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("first_edge_idle", 8'd0, 3'd0);

        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("result%0d_entry%0d", k, k % 16),
                  tbl[k % 16].d, tbl[k % 16].t);
        end

        #3;
        rst = 1'b0;
        #1;
        check("async_clear", 8'd0, 3'd0);
        @(posedge clk);
        #1;
        check("mid_reset_hold", 8'd0, 3'd0);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("restart_idle", 8'd0, 3'd0);
        @(posedge clk);
        #1;
        check("restart_entry0", 8'd127, 3'd1);
        @(posedge clk);
        #1;
        check("restart_entry1", tbl[1].d, tbl[1].t);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
